// File: rtl/ysyx_22040895_mdu_ctrl_if.sv
// Request/response bundle between the decode stage and the multiply/divide unit.
//   mduop_i  : 4-bit op (0001 mul, 0101 mulw, 1001 divw, 1101 remw, else no request)
//   src1_i   : rs1 operand
//   src2_i   : rs2 operand
//   flush_i  : pipeline flush, aborts any operation in flight
//   ready_o  : unit idle and able to accept
//   stall_o  : hold the pipeline while an operation is in flight
//   done_o   : one-cycle completion pulse
//   result_o : last completed result, held until the next completion
interface ysyx_22040895_mdu_ctrl_if;
  logic [3:0]  mduop_i;
  logic [63:0] src1_i;
  logic [63:0] src2_i;
  logic        flush_i;
  logic        ready_o;
  logic        stall_o;
  logic        done_o;
  logic [63:0] result_o;

  modport master (
    output mduop_i, src1_i, src2_i, flush_i,
    input  ready_o, stall_o, done_o, result_o
  );

  modport slave (
    input  mduop_i, src1_i, src2_i, flush_i,
    output ready_o, stall_o, done_o, result_o
  );
endinterface

// File: rtl/ysyx_22040895_mdu_ctrl.sv
// Iterative multiply/divide unit.
//   mul  : 64-cycle radix-2 shift-add, low 64 bits of the product
//   mulw : 32-cycle shift-add on the low words, sign-extended low 32 bits
//   divw/remw : 32-cycle restoring division on magnitudes, signs fixed up
//               afterwards; divide-by-zero and INT_MIN/-1 finish at once.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : slave side of the mdu_ctrl interface (op, operands, flush in;
//          ready, stall, done, result out)
// Timeline: accept in cycle 0, CALC for K cycles, FIX, then DONE (done_o).
module ysyx_22040895_mdu_ctrl (
  input logic                      clk,
  input logic                      rst,
  ysyx_22040895_mdu_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] OP_MUL  = 4'b0001;
  localparam logic [3:0] OP_MULW = 4'b0101;
  localparam logic [3:0] OP_DIVW = 4'b1001;
  localparam logic [3:0] OP_REMW = 4'b1101;

  logic [1:0]  state;
  logic [3:0]  op_q;
  logic [6:0]  cnt;
  // mul: acc = partial product, mcand = shifted multiplicand, mplier = multiplier
  // div: acc[31:0] = partial remainder, mcand[31:0] = |divisor|,
  //      mplier[31:0] = dividend bits shifting out / quotient bits shifting in
  logic [63:0] acc, mcand, mplier;
  logic        neg_q, neg_r;
  logic [63:0] result_q;

  // ---------------- request decode ----------------
  logic        req_valid, req_div, div_zero, div_ovf, fast_path;
  logic [31:0] s1w, s2w, s1_mag, s2_mag;
  logic [63:0] fast_res;

  assign s1w       = bus.src1_i[31:0];
  assign s2w       = bus.src2_i[31:0];
  assign req_valid = (bus.mduop_i == OP_MUL)  || (bus.mduop_i == OP_MULW) ||
                     (bus.mduop_i == OP_DIVW) || (bus.mduop_i == OP_REMW);
  assign req_div   = bus.mduop_i[3];
  assign div_zero  = (s2w == 32'd0);
  assign div_ovf   = (s1w == 32'h8000_0000) && (s2w == 32'hFFFF_FFFF);
  assign fast_path = req_div && (div_zero || div_ovf);
  assign s1_mag    = s1w[31] ? (32'd0 - s1w) : s1w;
  assign s2_mag    = s2w[31] ? (32'd0 - s2w) : s2w;

  // bit 2 separates remw from divw among the divide ops
  always_comb begin
    fast_res = 64'd0;
    if (div_zero)
      fast_res = bus.mduop_i[2] ? {{32{s1w[31]}}, s1w} : 64'hFFFF_FFFF_FFFF_FFFF;
    else
      fast_res = bus.mduop_i[2] ? 64'd0 : 64'hFFFF_FFFF_8000_0000;
  end

  // ---------------- iteration step ----------------
  logic [32:0] rem_sh, diff;
  assign rem_sh = {acc[31:0], mplier[31]};
  assign diff   = rem_sh - {1'b0, mcand[31:0]};

  // ---------------- sign fix-up ----------------
  logic [31:0] q_s, r_s;
  logic [63:0] fix_res;
  assign q_s = neg_q ? (32'd0 - mplier[31:0]) : mplier[31:0];
  assign r_s = neg_r ? (32'd0 - acc[31:0])    : acc[31:0];

  always_comb begin
    fix_res = acc;
    case (op_q)
      OP_MULW: fix_res = {{32{acc[31]}}, acc[31:0]};
      OP_DIVW: fix_res = {{32{q_s[31]}}, q_s};
      OP_REMW: fix_res = {{32{r_s[31]}}, r_s};
      default: fix_res = acc;
    endcase
  end

  // ---------------- FSM + datapath ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      op_q     <= 4'd0;
      cnt      <= 7'd0;
      acc      <= 64'd0;
      mcand    <= 64'd0;
      mplier   <= 64'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= 64'd0;
    end else if (bus.flush_i) begin
      // abort wherever we are; result_q is deliberately left alone
      state <= IDLE;
      cnt   <= 7'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_q  <= bus.mduop_i;
          neg_q <= s1w[31] ^ s2w[31];
          neg_r <= s1w[31];
          acc   <= 64'd0;
          if (fast_path) begin
            state    <= DONE;
            cnt      <= 7'd0;
            result_q <= fast_res;
          end else begin
            state <= CALC;
            cnt   <= (bus.mduop_i == OP_MUL) ? 7'd64 : 7'd32;
            if (req_div) begin
              mcand  <= {32'd0, s2_mag};
              mplier <= {32'd0, s1_mag};
            end else if (bus.mduop_i == OP_MUL) begin
              mcand  <= bus.src1_i;
              mplier <= bus.src2_i;
            end else begin
              mcand  <= {32'd0, s1w};
              mplier <= {32'd0, s2w};
            end
          end
        end
        CALC: begin
          if (op_q[3]) begin
            // restoring step: keep the subtraction only if it did not go negative
            acc[31:0]    <= diff[32] ? rem_sh[31:0] : diff[31:0];
            mplier[31:0] <= {mplier[30:0], ~diff[32]};
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= {mcand[62:0], 1'b0};
            mplier <= {1'b0, mplier[63:1]};
          end
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1) state <= FIX;
        end
        FIX: begin
          result_q <= fix_res;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o  = (state == IDLE);
  assign bus.done_o   = (state == DONE);
  assign bus.stall_o  = ((state == IDLE) && req_valid && !bus.flush_i) ||
                        (state == CALC) || (state == FIX);
  assign bus.result_o = result_q;

endmodule

// File: doc/ysyx_22040895_mdu_ctrl.md
YSYX_22040895_MDU_CTRL -- requirements
Module: ysyx_22040895_mdu_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as listed below.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 mduop_i  input  4  op from the decoder: 0001 mul, 0101 mulw, 1001 divw, 1101 remw; any other code is not a request.
REQ-005 src1_i  input  64  rs1 operand.
REQ-006 src2_i  input  64  rs2 operand.
REQ-007 flush_i  input  1  pipeline flush; aborts any operation.
REQ-008 ready_o  output  1  high only in IDLE.
REQ-009 stall_o  output  1  pipeline stall request.
REQ-010 done_o  output  1  one-cycle completion pulse.
REQ-011 result_o  output  64  last completed result; held until the next completion.

Function
REQ-012 FSM states SHALL be IDLE, CALC, FIX and DONE.
REQ-013 Accept SHALL occur when state=IDLE, mduop_i is a valid code and flush_i=0 (acceptance cycle = cycle 0).
REQ-014 At accept, the block SHALL latch op, src1_i and src2_i; input changes afterwards have no effect.
REQ-015 Normal path: IDLE -> CALC for K cycles (cycles 1..K) -> FIX (cycle K+1) -> DONE (cycle K+2, done_o=1) -> IDLE.
REQ-016 K SHALL be 64 for mul and 32 for mulw, divw and remw, counted by an iteration counter loaded at accept.
REQ-017 mul: radix-2 shift-add over 64 bits; result = low 64 bits of src1*src2 (signedness irrelevant).
REQ-018 mulw: shift-add over src1[31:0] and src2[31:0]; result = sign-extended low 32 bits of the product.
REQ-019 divw/remw: signed 32-bit restoring division on magnitudes of src1[31:0] and src2[31:0]; FIX applies signs.
- Quotient is negative iff the operand signs differ.
- Remainder takes the dividend's sign.
- Result is the sign-extended 32-bit quotient or remainder.
REQ-020 Divide by zero (src2[31:0]=0) SHALL go IDLE -> DONE directly, with done_o in cycle 1.
- divw result: 0xFFFF_FFFF_FFFF_FFFF.
- remw result: sign-extended src1[31:0].
REQ-021 Overflow (src1[31:0]=0x8000_0000 and src2[31:0]=0xFFFF_FFFF) SHALL go IDLE -> DONE directly.
- divw result: 0xFFFF_FFFF_8000_0000.
- remw result: 0.
REQ-022 Upper 32 source bits SHALL be ignored for all word ops, including the zero and overflow checks.
REQ-023 stall_o SHALL equal (IDLE & valid mduop_i & ~flush_i) | CALC | FIX; it is 0 in DONE so the pipeline advances exactly on done_o.
REQ-024 result_o SHALL update only on the edge entering DONE and hold otherwise.
REQ-025 ready_o=0 in CALC, FIX and DONE; back-to-back ops SHALL be accepted no earlier than the IDLE cycle after DONE.
REQ-026 flush_i=1 in any state: next state IDLE, no done_o pulse, result_o unchanged, counter cleared.
REQ-027 flush_i and a valid request in the same IDLE cycle: flush wins and nothing is accepted.
REQ-028 flush_i in DONE: done_o still pulses in that cycle, then the FSM returns to IDLE.

Reset
REQ-029 rst=0 SHALL immediately force, regardless of clk: state=IDLE, counter=0, all datapath registers=0, result_o=0, done_o=0, ready_o=1.
- stall_o then follows REQ-023 combinationally.
REQ-030 Reset asserted mid-operation SHALL abandon it with no done_o; normal accept resumes on the first clock edge after rst=1.

Verification
REQ-031 mul, src1=3, src2=0xFFFF_FFFF_FFFF_FFFB -> done_o in cycle 66, result_o=0xFFFF_FFFF_FFFF_FFF1, stall_o=1 in cycles 0..65.
REQ-032 mulw, src1=0xDEAD_0000_7FFF_FFFF, src2=2 -> done_o in cycle 34, result_o=0xFFFF_FFFF_FFFF_FFFE.
REQ-033 divw -7/2 -> 0xFFFF_FFFF_FFFF_FFFD at cycle 34; remw -7%2 -> 0xFFFF_FFFF_FFFF_FFFF; remw 7%-2 -> 1.
REQ-034 divw, src1=5, src2=0x1_0000_0000 -> done_o in cycle 1, result_o=all ones.
- remw with the same operands -> 5.
- divw 0x8000_0000 / 0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000; remw with the same operands -> 0.
REQ-035 mul accepted, flush_i at cycle 10 -> no done_o, ready_o=1 at cycle 11, result_o unchanged; a new divw accepted in cycle 11 completes in cycle 45.
REQ-036 rst asserted at cycle 20 of mul, between clock edges -> outputs are at reset values before the next edge, done_o never pulses; a following mulw completes correctly.
